// File: rtl/i2c_pkg.sv
// Shared codes for the I2C register-read sequencer.
// Command codes, FSM state codes and mode-byte field positions.
package i2c_pkg;

    localparam int CMD_W = 3;

    localparam logic [CMD_W-1:0] CMD_START     = 3'd1;
    localparam logic [CMD_W-1:0] CMD_WRITE     = 3'd2;
    localparam logic [CMD_W-1:0] CMD_READ_NACK = 3'd3;
    localparam logic [CMD_W-1:0] CMD_RSTART    = 3'd4;
    localparam logic [CMD_W-1:0] CMD_STOP      = 3'd5;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_START  = 4'd1,
        ST_ADDR_W = 4'd2,
        ST_REG    = 4'd3,
        ST_RSTART = 4'd4,
        ST_ADDR_R = 4'd5,
        ST_READ   = 4'd6,
        ST_STOP   = 4'd7,
        ST_DONE   = 4'd8
    } state_t;

    localparam int MODE_ERR     = 7;
    localparam int MODE_RTY_LSB = 4;
    localparam int MODE_ST_LSB  = 0;

    function automatic logic [CMD_W-1:0] st_cmd(input state_t s);
        logic [CMD_W-1:0] c;
        case (s)
            ST_START:  c = CMD_START;
            ST_ADDR_W: c = CMD_WRITE;
            ST_REG:    c = CMD_WRITE;
            ST_ADDR_R: c = CMD_WRITE;
            ST_RSTART: c = CMD_RSTART;
            ST_READ:   c = CMD_READ_NACK;
            ST_STOP:   c = CMD_STOP;
            default:   c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/i2c_req_sync.sv
// Request synchroniser: 2-FF sync of the raw switch plus a
// one-cycle pulse on its falling edge. Idles high.
module i2c_req_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic fall
);

    logic [2:0] sr;

    // sr[1] is the synchronised level, sr[2] its one-cycle delay
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sr <= 3'b111;
        else        sr <= {sr[1:0], din};
    end

    assign fall = sr[2] & ~sr[1];

endmodule

// File: rtl/i2c_reg_rd_seq.sv
// I2C register-read transaction sequencer with NACK retry.
// Optional response watchdog: define I2C_TIMEOUT_EN.
module i2c_reg_rd_seq
    import i2c_pkg::*;
#(
    parameter int unsigned RETRY_MAX   = 3,
    parameter int unsigned TIMEOUT_CYC = 4096
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_n,
    input  logic [6:0]       dev_addr,
    input  logic [7:0]       reg_addr,
    output logic             cmd_valid,
    output logic [CMD_W-1:0] cmd,
    output logic [7:0]       cmd_data,
    input  logic             cmd_ready,
    input  logic             rsp_valid,
    input  logic             rsp_ack,
    input  logic [7:0]       rsp_data,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [7:0]       rd_data,
    output logic [7:0]       mode
);

    state_t     state, state_nx;
    logic       req_fall;
    logic       wait_ph, nack_flag, err_q;
    logic [2:0] retry_cnt;
    logic [6:0] dev_q;
    logic [7:0] reg_q, shadow, rd_q;
    logic       is_cmd, xfer, rsp_ok, nack, retry, tmo;

    i2c_req_sync u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (start_n),
        .fall  (req_fall)
    );

    assign is_cmd = (state != ST_IDLE) && (state != ST_DONE);
    assign xfer   = cmd_valid & cmd_ready;
    assign rsp_ok = wait_ph & rsp_valid;
    assign nack   = rsp_ok & ~rsp_ack &
                    ((state == ST_ADDR_W) || (state == ST_REG) ||
                     (state == ST_ADDR_R));
    // A timed-out transaction is flagged in err and never retried
    assign retry  = nack_flag & ~err_q &
                    (32'(retry_cnt) < RETRY_MAX);

`ifdef I2C_TIMEOUT_EN
    logic [15:0] tmr;

    // Watchdog: restarts at each handshake, runs during wait phase
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       tmr <= '0;
        else if (xfer)    tmr <= '0;
        else if (wait_ph) tmr <= tmr + 16'd1;
    end

    assign tmo = wait_ph & ~rsp_valid &
                 (tmr == 16'(TIMEOUT_CYC - 1));
`else
    assign tmo = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nx;
    end

    // Next-state: advance on response, divert to STOP on NACK/timeout
    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE: if (req_fall) state_nx = ST_START;
            ST_DONE: state_nx = ST_IDLE;
            default: begin
                if (rsp_ok) begin
                    unique case (state)
                        ST_START:  state_nx = ST_ADDR_W;
                        ST_ADDR_W: state_nx = rsp_ack ? ST_REG : ST_STOP;
                        ST_REG:    state_nx = rsp_ack ? ST_RSTART : ST_STOP;
                        ST_RSTART: state_nx = ST_ADDR_R;
                        ST_ADDR_R: state_nx = rsp_ack ? ST_READ : ST_STOP;
                        ST_READ:   state_nx = ST_STOP;
                        ST_STOP:   state_nx = retry ? ST_START : ST_DONE;
                        default:   state_nx = state;
                    endcase
                end else if (tmo) begin
                    state_nx = (state == ST_STOP) ? ST_DONE : ST_STOP;
                end
            end
        endcase
    end

    // Phase, retry bookkeeping, request latch and read-data capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_ph   <= 1'b0;
            nack_flag <= 1'b0;
            err_q     <= 1'b0;
            retry_cnt <= '0;
            dev_q     <= '0;
            reg_q     <= '0;
            shadow    <= '0;
            rd_q      <= '0;
        end else begin
            if (state_nx != state) wait_ph <= 1'b0;
            else if (xfer)         wait_ph <= 1'b1;
            if ((state == ST_IDLE) && req_fall) begin
                dev_q     <= dev_addr;
                reg_q     <= reg_addr;
                retry_cnt <= '0;
                err_q     <= 1'b0;
                nack_flag <= 1'b0;
            end
            if (nack) nack_flag <= 1'b1;
            if ((state == ST_STOP) && rsp_ok) begin
                if (retry) begin
                    retry_cnt <= retry_cnt + 3'd1;
                    nack_flag <= 1'b0;
                end else if (nack_flag) begin
                    err_q <= 1'b1;
                end
            end
            if (tmo) err_q <= 1'b1;
            if ((state == ST_READ) && rsp_ok) shadow <= rsp_data;
            if ((state == ST_DONE) && !err_q) rd_q <= shadow;
        end
    end

    // Outputs decoded from state and phase
    always_comb begin
        cmd_valid = is_cmd & ~wait_ph;
        cmd       = cmd_valid ? st_cmd(state) : '0;
        cmd_data  = '0;
        if (cmd_valid) begin
            unique case (1'b1)
                state == ST_ADDR_W: cmd_data = {dev_q, 1'b0};
                state == ST_REG:    cmd_data = reg_q;
                state == ST_ADDR_R: cmd_data = {dev_q, 1'b1};
                default:            cmd_data = '0;
            endcase
        end
        busy = (state != ST_IDLE);
        done = (state == ST_DONE);
        mode = '0;
        mode[MODE_ERR]             = err_q;
        mode[MODE_RTY_LSB +: 3]    = retry_cnt;
        mode[MODE_ST_LSB +: 4]     = state;
    end

    assign err     = err_q;
    assign rd_data = rd_q;

endmodule
